// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks in-flight writers past EX, selects
// bypass sources for EX read ports and stalls ID readers of too-young loads.
module fwd_hazard_unit #(
  parameter  int REG_AW     = 5,
  parameter  int N_RD       = 2,
  parameter  int DEPTH      = 2,
  parameter  int LOAD_STAGE = 2,
  localparam int SW         = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     adv,
  input  logic                     ex_valid,
  input  logic                     ex_regwrite,
  input  logic                     ex_memread,
  input  logic [REG_AW-1:0]        ex_rd,
  input  logic [N_RD*REG_AW-1:0]   ex_rs,
  input  logic [N_RD*REG_AW-1:0]   id_rs,
  input  logic                     id_valid,
  output logic [N_RD*SW-1:0]       fwd_sel,
  output logic                     stall,
  output logic [15:0]              stall_cnt
);

  typedef struct packed {
    logic              v;
    logic              ld;
    logic [REG_AW-1:0] rd;
  } entry_t;

  entry_t trk [1:DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the pre-edge value of its predecessor; blocking here would collapse the shift.
  // NOTE: only the valid bits are reset; ld/rd are don't-care while v=0, so the
  // tracker payload needs no reset network.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 1; s <= DEPTH; s++) trk[s].v <= 1'b0;
    end else if (adv) begin
      trk[1] <= '{v:  ex_valid & ex_regwrite & (ex_rd != '0),
                  ld: ex_memread,
                  rd: ex_rd};
      for (int s = 2; s <= DEPTH; s++) trk[s] <= trk[s-1];
    end
  end

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    fwd_sel = '0;
    if (!rst) begin
      for (int p = 0; p < N_RD; p++) begin
        // Walk oldest to youngest so the nearest stage overwrites older hits.
        for (int s = DEPTH; s >= 1; s--) begin
          if (trk[s].v && (trk[s].rd == ex_rs[p*REG_AW +: REG_AW]))
            fwd_sel[p*SW +: SW] = SW'(DEPTH + 1 - s);
        end
      end
    end
  end

  always_comb begin
    stall = 1'b0;
    if (!rst && id_valid) begin
      for (int p = 0; p < N_RD; p++) begin
        if (id_rs[p*REG_AW +: REG_AW] != '0) begin
          if ((LOAD_STAGE > 1) && ex_valid && ex_regwrite && ex_memread &&
              (ex_rd == id_rs[p*REG_AW +: REG_AW]))
            stall = 1'b1;
          // A load in stage s reaches the forwardable stage only if s+1 >= LOAD_STAGE.
          for (int s = 1; s <= DEPTH; s++) begin
            if ((s + 1 < LOAD_STAGE) && trk[s].v && trk[s].ld &&
                (trk[s].rd == id_rs[p*REG_AW +: REG_AW]))
              stall = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && adv && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: a default instance and a DEPTH=3,
// LOAD_STAGE=3 instance share stimulus; expectations are queued then compared.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst, adv;
  logic        ex_valid, ex_regwrite, ex_memread;
  logic [4:0]  ex_rd;
  logic [9:0]  ex_rs, id_rs;
  logic        id_valid;
  logic [3:0]  sel2, sel3;
  logic        stall2, stall3;
  logic [15:0] cnt2, cnt3;

  always #5 clk = ~clk;

  fwd_hazard_unit u_dut2 (
    .clk(clk), .rst(rst), .adv(adv), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_rs(ex_rs), .id_rs(id_rs),
    .id_valid(id_valid), .fwd_sel(sel2), .stall(stall2), .stall_cnt(cnt2)
  );

  fwd_hazard_unit #(.DEPTH(3), .LOAD_STAGE(3)) u_dut3 (
    .clk(clk), .rst(rst), .adv(adv), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_rs(ex_rs), .id_rs(id_rs),
    .id_valid(id_valid), .fwd_sel(sel3), .stall(stall3), .stall_cnt(cnt3)
  );

  typedef enum int {SEL2_P0, SEL2_P1, STALL2, CNT2, SEL3_P0, SEL3_P1, STALL3, CNT3} sig_e;
  typedef struct {
    string tag;
    sig_e  sig;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      SEL2_P0: return 32'(sel2[1:0]);
      SEL2_P1: return 32'(sel2[3:2]);
      STALL2:  return 32'(stall2);
      CNT2:    return 32'(cnt2);
      SEL3_P0: return 32'(sel3[1:0]);
      SEL3_P1: return 32'(sel3[3:2]);
      STALL3:  return 32'(stall3);
      default: return 32'(cnt3);
    endcase
  endfunction

  task automatic push_exp(input string tag, input sig_e s, input int v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  // Compare queued expectations mid-cycle, then advance one clock edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sig), e.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic rw, input logic mr,
                        input int rd, input int rs0, input int rs1);
    ex_valid    = v;
    ex_regwrite = rw;
    ex_memread  = mr;
    ex_rd       = 5'(rd);
    ex_rs       = {5'(rs1), 5'(rs0)};
  endtask

  task automatic set_id(input logic v, input int rs0, input int rs1);
    id_valid = v;
    id_rs    = {5'(rs1), 5'(rs0)};
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    // Reset held with an active load writer and matching readers.
    rst = 1'b1;
    adv = 1'b1;
    set_ex(1, 1, 1, 5, 5, 5);
    set_id(1, 5, 5);
    push_exp("rst_sel_p0", SEL2_P0, 0);
    push_exp("rst_sel_p1", SEL2_P1, 0);
    push_exp("rst_stall", STALL2, 0);
    push_exp("rst_stall3", STALL3, 0);
    push_exp("rst_sel3_p0", SEL3_P0, 0);
    step();
    push_exp("rst_cnt", CNT2, 0);
    push_exp("rst_stall_b", STALL2, 0);
    push_exp("rst_sel_b", SEL2_P0, 0);
    step();

    rst = 1'b0;
    set_ex(0, 0, 0, 0, 5, 5);
    set_id(0, 0, 0);
    push_exp("post_rst_sel_p0", SEL2_P0, 0);
    push_exp("post_rst_sel_p1", SEL2_P1, 0);
    push_exp("post_rst_cnt", CNT2, 0);
    push_exp("post_rst_stall", STALL2, 0);
    step();

    // Back-to-back ALU: writer r8 then reader r8.
    set_ex(1, 1, 0, 8, 0, 0);
    push_exp("alu_pre", SEL2_P0, 0);
    step();
    set_ex(1, 0, 0, 0, 8, 0);
    push_exp("alu_exm", SEL2_P0, 2);
    step();
    set_ex(0, 0, 0, 0, 8, 0);
    push_exp("alu_mwb", SEL2_P0, 1);
    step();
    push_exp("alu_gone", SEL2_P0, 0);
    step();

    // Priority: r9 in both stages, nearest wins.
    set_ex(1, 1, 0, 9, 0, 0);
    step();
    step();
    set_ex(0, 0, 0, 0, 9, 9);
    push_exp("prio_p0", SEL2_P0, 2);
    push_exp("prio_p1", SEL2_P1, 2);
    push_exp("prio3_p0", SEL3_P0, 3);
    step();

    // Writer to r0 is never tracked.
    set_ex(1, 1, 0, 0, 0, 0);
    step();
    set_ex(0, 0, 0, 0, 0, 0);
    push_exp("r0_p0", SEL2_P0, 0);
    push_exp("r0_p1", SEL2_P1, 0);
    step();

    // Load-use with defaults: one bubble.
    set_ex(1, 1, 1, 4, 0, 0);
    set_id(1, 7, 4);
    push_exp("lu_stall", STALL2, 1);
    push_exp("lu_cnt0", CNT2, 0);
    step();
    set_ex(0, 0, 0, 0, 0, 0);
    push_exp("lu_release", STALL2, 0);
    push_exp("lu_cnt1", CNT2, 1);
    step();
    set_ex(1, 1, 0, 10, 7, 4);
    set_id(0, 0, 0);
    push_exp("lu_fwd_p1", SEL2_P1, 1);
    push_exp("lu_fwd_p0", SEL2_P0, 0);
    push_exp("lu_stall_off", STALL2, 0);
    push_exp("lu_cnt_hold", CNT2, 1);
    step();

    // Freeze with a writer in stage 1 and a load stall pending.
    set_ex(1, 1, 0, 11, 0, 0);
    step();
    adv = 1'b0;
    set_ex(1, 1, 1, 12, 11, 12);
    set_id(1, 12, 0);
    for (int i = 0; i < 3; i++) begin
      push_exp($sformatf("frz_p0_%0d", i), SEL2_P0, 2);
      push_exp($sformatf("frz_p1_%0d", i), SEL2_P1, 0);
      push_exp($sformatf("frz_stall_%0d", i), STALL2, 1);
      push_exp($sformatf("frz_cnt_%0d", i), CNT2, 1);
      step();
    end
    adv = 1'b1;
    push_exp("thaw_stall", STALL2, 1);
    push_exp("thaw_cnt", CNT2, 1);
    push_exp("thaw_p0", SEL2_P0, 2);
    step();
    set_id(0, 0, 0);
    set_ex(0, 0, 0, 0, 11, 12);
    push_exp("thaw_cnt_inc", CNT2, 2);
    push_exp("thaw_new_p1", SEL2_P1, 2);
    push_exp("thaw_old_p0", SEL2_P0, 1);
    push_exp("thaw_stall_off", STALL2, 0);
    step();

    // DEPTH=3, LOAD_STAGE=3: two-cycle load-use stall.
    rst = 1'b1;
    push_exp("d3_rst_stall", STALL3, 0);
    push_exp("d3_rst_sel", SEL3_P0, 0);
    step();
    rst = 1'b0;
    set_ex(1, 1, 1, 6, 0, 0);
    set_id(1, 6, 0);
    push_exp("d3_stall_a", STALL3, 1);
    push_exp("d3_cnt_a", CNT3, 0);
    step();
    set_ex(0, 0, 0, 0, 0, 0);
    push_exp("d3_stall_b", STALL3, 1);
    push_exp("d3_cnt_b", CNT3, 1);
    step();
    push_exp("d3_release", STALL3, 0);
    push_exp("d3_cnt_c", CNT3, 2);
    step();
    set_ex(1, 1, 0, 13, 6, 0);
    set_id(0, 0, 0);
    push_exp("d3_fwd_s3", SEL3_P0, 1);
    push_exp("d3_cnt_final", CNT3, 2);
    push_exp("d3_stall_off", STALL3, 0);
    step();
    set_ex(0, 0, 0, 0, 13, 6);
    push_exp("d3_fwd_s1", SEL3_P0, 3);
    push_exp("d3_load_gone", SEL3_P1, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
